// File: rtl/fetch_buffer.sv
// Instruction fetch FIFO: 1-cycle push-to-head latency (0 with FETCH_BUFFER_BYPASS_EN); buble stalls the PC
// one slot early, and an input arriving at a full buffer with no pop is dropped and flagged in overflow.
module fetch_buffer #(
    parameter int size  = 32,
    parameter int depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [size-1:0]              in_instr,
    input  logic [size-1:0]              in_pc,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [size-1:0]              out_instr,
    output logic [size-1:0]              out_pc,
    output logic                         buble,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         overflow
);
    localparam int pw = $clog2(depth);
    localparam int cw = $clog2(depth+1);
    localparam logic [cw-1:0] full   = cw'(depth);
    localparam logic [cw-1:0] almost = cw'(depth - 1);

    logic [size-1:0] instr_mem [depth];
    logic [size-1:0] pc_mem    [depth];
    logic [pw-1:0]   rd_ptr;
    logic [pw-1:0]   wr_ptr;
    logic            empty;
    logic            bypass;
    logic            pop;
    logic            push;
    logic            drop;

    assign empty = (count == '0);

`ifdef FETCH_BUFFER_BYPASS_EN
    // Empty buffer forwards the fetched instruction straight through; gated so reset forces zeros.
    assign bypass    = empty & in_valid & ~flush & out_ready;
    assign out_valid = ~reset & (~empty | (in_valid & ~flush));
    assign out_instr = reset ? '0 : (empty ? in_instr : instr_mem[rd_ptr]);
    assign out_pc    = reset ? '0 : (empty ? in_pc    : pc_mem[rd_ptr]);
`else
    assign bypass    = 1'b0;
    assign out_valid = ~empty;
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];
`endif

    // Storage pop only; a bypassed instruction never enters storage so count stays put.
    assign pop   = ~empty & out_ready & ~flush;
    assign push  = in_valid & ~flush & ~bypass & ((count != full) | pop);
    assign drop  = in_valid & ~flush & (count == full) & ~pop;
    assign buble = (count >= almost);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < depth; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else begin
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    instr_mem[wr_ptr] <= in_instr;
                    pc_mem[wr_ptr]    <= in_pc;
                    wr_ptr            <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
